// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO drain controller: pops words and streams them out lane by lane (optional txPar via FIFO_READER_PARITY_EN)
module fifo_reader #(
  parameter int DATA_W    = 32,
  parameter int LANE_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              EN,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] dataOut,
  output logic              RD,
  output logic [LANE_W-1:0] txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              txLast,
  output logic              busy,
  output logic [15:0]       wordCount
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic              txPar
`endif
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   lane_idx;
  logic [15:0]        word_cnt;
  logic [LANE_W-1:0]  lane_sel;
  logic               lane_last;
  logic               fetch;
  logic               accept;

  assign lane_last = (lane_idx == IDX_W'(LANES - 1));
  assign fetch     = (state == IDLE) && EN && !EMPTY;
  assign accept    = (state == SEND) && txReady;

  // State register; reset drops straight back to IDLE, discarding any word in flight
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: EN/EMPTY only matter in IDLE, once committed a word always completes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    if (txReady && lane_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read strobe, word capture, lane stepping and completed-word counter
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      RD       <= 1'b0;
      shreg    <= '0;
      lane_idx <= '0;
      word_cnt <= '0;
    end else begin
      RD <= fetch;
      if (state == WAIT) begin
        shreg    <= dataOut;
        lane_idx <= '0;
      end else if (accept) begin
        if (lane_last) begin
          lane_idx <= '0;
          word_cnt <= word_cnt + 16'd1;
        end else begin
          lane_idx <= lane_idx + IDX_W'(1);
        end
      end
    end
  end

  // Lane multiplexer; lane 0 is the top slice when MSB_FIRST, else the bottom slice
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == IDX_W'(i)) begin
        if (MSB_FIRST) begin
          lane_sel = shreg[DATA_W-1-i*LANE_W -: LANE_W];
        end else begin
          lane_sel = shreg[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign txValid   = (state == SEND);
  assign txData    = txValid ? lane_sel : '0;
  assign txLast    = txValid && lane_last;
  assign busy      = (state != IDLE);
  assign wordCount = word_cnt;

`ifdef FIFO_READER_PARITY_EN
  assign txPar = ^txData;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader with a FIFO model and lane scoreboard
module tb_fifo_reader;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;

  logic              CLK;
  logic              rst;
  logic              EN;
  logic              EMPTY;
  logic [DATA_W-1:0] dataOut;
  logic              RD;
  logic [LANE_W-1:0] txData;
  logic              txValid;
  logic              txReady;
  logic              txLast;
  logic              busy;
  logic [15:0]       wordCount;
`ifdef FIFO_READER_PARITY_EN
  logic              txPar;
`endif

  fifo_reader #(.DATA_W(DATA_W), .LANE_W(LANE_W), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .rst(rst), .EN(EN), .EMPTY(EMPTY), .dataOut(dataOut), .RD(RD),
    .txData(txData), .txValid(txValid), .txReady(txReady), .txLast(txLast),
    .busy(busy), .wordCount(wordCount)
`ifdef FIFO_READER_PARITY_EN
    , .txPar(txPar)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FIFO model storage
  logic [31:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // scoreboard / reference model state
  logic [31:0] exp_q [$];
  int          k = 0;
  logic [15:0] model_count = 16'd0;
  int          rd_pulses = 0;
  int          rise_q [$];
  logic        rd_prev = 1'b0;
  logic        en_prev = 1'b0;
  logic        empty_prev = 1'b1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  assign EMPTY = (wr_ptr == rd_ptr);

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask

  // FIFO read port: a word is popped when RD is sampled high, dataOut valid next cycle
  always @(posedge CLK) begin
    if (RD) begin
      dataOut <= mem[rd_ptr % 16];
      exp_q.push_back(mem[rd_ptr % 16]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Compare process: every cycle, DUT outputs against the word/lane model
  always @(negedge CLK) begin
    if (!rst) begin
      exp_q.delete();
      k = 0;
      model_count = 16'd0;
    end else begin
      logic [31:0] w;
      logic [7:0]  lane;
      check("wordCount", {16'd0, wordCount}, {16'd0, model_count});
      check("outstanding<=1", {31'd0, (exp_q.size() <= 1)}, 32'd1);
      if (RD && !rd_prev) begin
        rd_pulses++;
        rise_q.push_back(cyc);
        check("rd_rise_needs_en_nonempty", {31'd0, en_prev && !empty_prev}, 32'd1);
      end
      if (RD && rd_prev) check("rd_single_cycle", 32'd1, 32'd0);
      if (txValid) begin
        if (exp_q.size() == 0) begin
          check("txValid_without_pop", 32'd1, 32'd0);
        end else begin
          w    = exp_q[0];
          lane = 8'((w >> (LANE_W * (LANES - 1 - k))) & 32'hFF);
          check("txData", {24'd0, txData}, {24'd0, lane});
          check("txLast", {31'd0, txLast}, {31'd0, (k == LANES - 1)});
`ifdef FIFO_READER_PARITY_EN
          check("txPar", {31'd0, txPar}, {31'd0, ^lane});
`endif
          if (txReady) begin
            if (k == LANES - 1) begin
              k = 0;
              void'(exp_q.pop_front());
              model_count = model_count + 16'd1;
            end else begin
              k++;
            end
          end
        end
      end else begin
        check("txLast_idle", {31'd0, txLast}, 32'd0);
      end
    end
    rd_prev    = RD;
    en_prev    = EN;
    empty_prev = EMPTY;
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (!txValid && n < 30) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!txValid) begin
      errors++;
      $display("FAIL %s timeout txValid=%0b required 1", nm, txValid);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] lanes_a [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] par_exp [4] = '{8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    int base;
    int n;
    int p0;
    rst = 1'b0; EN = 1'b0; txReady = 1'b1; dataOut = '0;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_RD", {31'd0, RD}, 32'd0);
    check("reset_txValid", {31'd0, txValid}, 32'd0);
    check("reset_txLast", {31'd0, txLast}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_txData", {24'd0, txData}, 32'd0);
    check("reset_wordCount", {16'd0, wordCount}, 32'd0);
    tick();
    rst = 1'b1;

    // single word, MSB-first lanes
    tick();
    push(32'hA1B2C3D4);
    EN = 1'b1;
    wait_valid("single_valid");
    check("rd_to_valid_latency", cyc - rise_q[$], 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("single_lane", {24'd0, txData}, {24'd0, lanes_a[i]});
      check("single_last", {31'd0, txLast}, {31'd0, (i == 3)});
      @(negedge CLK);
    end
    check("single_wordCount", {16'd0, wordCount}, 32'd1);
    check("single_busy_done", {31'd0, busy}, 32'd0);
    check("single_rd_pulses", rd_pulses, 32'd1);
    tick();
    EN = 1'b0;

    // backpressure after lane 1, EN dropped during SEND
    tick();
    push(32'h11223344);
    EN = 1'b1;
    wait_valid("bp_valid");
    check("bp_lane0", {24'd0, txData}, 32'h11);
    tick();
    EN = 1'b0;
    txReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_hold_data", {24'd0, txData}, 32'h22);
      check("bp_hold_valid", {31'd0, txValid}, 32'd1);
    end
    tick();
    txReady = 1'b1;
    @(negedge CLK);
    check("bp_lane1", {24'd0, txData}, 32'h22);
    @(negedge CLK);
    check("bp_lane2", {24'd0, txData}, 32'h33);
    @(negedge CLK);
    check("bp_lane3", {24'd0, txData}, 32'h44);
    check("bp_last", {31'd0, txLast}, 32'd1);
    @(negedge CLK);
    check("bp_wordCount", {16'd0, wordCount}, 32'd2);

    // EMPTY with EN: no reads
    tick();
    EN = 1'b1;
    p0 = rd_pulses;
    repeat (20) tick();
    check("empty_no_rd", rd_pulses - p0, 32'd0);
    // data present but EN low: no reads
    EN = 1'b0;
    push(32'h55667788);
    repeat (20) tick();
    check("en_low_no_rd", rd_pulses - p0, 32'd0);
    check("en_low_busy", {31'd0, busy}, 32'd0);

    // back-to-back: three words queued
    push(32'h99AABBCC);
    push(32'h0F1E2D3C);
    base = rise_q.size();
    EN = 1'b1;
    n = 0;
    @(negedge CLK);
    while (wordCount != 16'd5 && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_wordCount", {16'd0, wordCount}, 32'd5);
    if (rise_q.size() >= base + 3) begin
      check("b2b_spacing_1", rise_q[base+1] - rise_q[base], 32'd7);
      check("b2b_spacing_2", rise_q[base+2] - rise_q[base+1], 32'd7);
    end else begin
      check("b2b_rd_count", rise_q.size() - base, 32'd3);
    end
    tick();
    EN = 1'b0;

    // wordCount wrap from 0xFFFF
    tick();
    force dut.word_cnt = 16'hFFFF;
    #1;
    release dut.word_cnt;
    model_count = 16'hFFFF;
    @(negedge CLK);
    check("wrap_preload", {16'd0, wordCount}, 32'h0000FFFF);
    tick();
    push(32'h01020304);
    EN = 1'b1;
    wait_valid("wrap_valid");
    repeat (4) @(negedge CLK);
    check("wrap_zero", {16'd0, wordCount}, 32'd0);
    tick();
    EN = 1'b0;

    // asynchronous reset mid-SEND
    tick();
    push(32'hDEADBEEF);
    EN = 1'b1;
    wait_valid("rst_valid");
    @(negedge CLK);
    #2;
    rst = 1'b0;
    #1;
    check("async_RD", {31'd0, RD}, 32'd0);
    check("async_txValid", {31'd0, txValid}, 32'd0);
    check("async_txLast", {31'd0, txLast}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_wordCount", {16'd0, wordCount}, 32'd0);
    EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b1;
    @(negedge CLK);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef FIFO_READER_PARITY_EN
    // parity over each lane
    tick();
    push(32'h0703FF00);
    EN = 1'b1;
    wait_valid("par_valid");
    for (int i = 0; i < 4; i++) begin
      check("par_lane", {31'd0, txPar}, {24'd0, par_exp[i]});
      @(negedge CLK);
    end
    tick();
    EN = 1'b0;
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
